wshb_ram_slave: RTL
===================

WSHB_RAM_SLAVE -- requirements
Module: wshb_ram_slave

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, Wishbone byte address width.
REQ-002 SHALL have parameter MEM_WORDS, default 1024, number of 32-bit words stored; power of two.
REQ-003 SHALL have parameter WAIT_STATES, default 0, extra cycles before the first ack of a transfer; range 0..7.
REQ-004 SHALL have ports, in order:
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cyc  in  1  bus cycle valid.
- stb  in  1  strobe.
- adr  in  ADDR_WIDTH  byte address; bits [1:0] ignored.
- we  in  1  1 = write.
- dat_ms  in  32  write data.
- sel  in  4  byte enables.
- cti  in  3  cycle type identifier.
- bte  in  2  burst type.
- ack  out  1  transfer acknowledge.
- err  out  1  error acknowledge.
- rty  out  1  retry; constant 0.
- dat_sm  out  32  read data.

Function
REQ-005 SHALL be a Wishbone B4 registered-feedback responder; ack, err and dat_sm SHALL be registered.
REQ-006 SHALL implement FSM states IDLE, WAIT, ACK, BURST.
REQ-007 IDLE: on cyc&stb, go to WAIT with count = WAIT_STATES, or to ACK if WAIT_STATES = 0.
REQ-008 WAIT: decrement the count each cycle; at 0, go to ACK.
REQ-009 In ACK, ack SHALL be high for exactly one cycle, WAIT_STATES+1 cycles after stb is first sampled high.
REQ-010 After ACK, the FSM SHALL go to IDLE. ack SHALL be low in the following cycle. A stb still high there SHALL start a new transfer.
REQ-011 Reads: dat_sm SHALL hold mem[adr[2+:log2(MEM_WORDS)]] in every cycle where ack is high.
- dat_sm SHALL be 0 in every other cycle.
REQ-012 Writes SHALL update only the bytes with sel[i]=1, in the cycle where ack is high, using the adr and dat_ms present in that cycle.
REQ-013 If the word index (adr >> 2) >= MEM_WORDS, err SHALL pulse in place of ack; no write; dat_sm = 0.
REQ-014 If cyc falls in any state, the FSM SHALL return to IDLE on the next edge. No ack/err SHALL follow and no write SHALL occur.
REQ-015 ack and err SHALL never be high in the same cycle; rty SHALL stay 0.

Reset
REQ-016 While rst_n is low: state = IDLE, ack = 0, err = 0, dat_sm = 0, wait count = 0.
- Applies immediately, independent of clk.
REQ-017 Memory contents SHALL NOT be cleared by reset.
REQ-018 Reset asserted mid-transfer SHALL abort the transfer with no ack and no write.
- After release, the first cyc&stb SHALL be treated as a new transfer.

Configuration
REQ-019 Macro WSHB_RAM_BURST_EN SHALL enable incremental bursts.
REQ-020 With the macro, cti=3'b010 and bte=2'b00 at the end of ACK SHALL enter BURST:
- ack high every cycle while stb=1; one data word per cycle.
- The internal address increments by 4 per ack.
- Read data is prefetched one word ahead.
- When stb=0 in BURST: ack low the next cycle, address held, resume when stb returns.
- The ack cycle with cti=3'b111 is the last; then the FSM goes to IDLE.
- The word index SHALL wrap modulo MEM_WORDS.
REQ-021 Without the macro, the BURST state SHALL not exist and every access SHALL be classic per REQ-007..010, whatever cti and bte are.
REQ-022 With the macro, bte != 2'b00 SHALL be handled as classic.

Verification
REQ-023 WAIT_STATES=0: write 0xDEADBEEF, sel=4'hF, adr=0x10; then read adr=0x10 -> ack 1 cycle after stb, dat_sm = 0xDEADBEEF, ack low the cycle after.
REQ-024 WAIT_STATES=3: read adr=0x10 -> ack exactly 4 cycles after stb sampled; dat_sm = 0xDEADBEEF.
REQ-025 sel=4'b0010, dat_ms=0x0000AB00 to adr=0x10, then read -> 0xDEADABEF.
REQ-026 adr=4*MEM_WORDS (0x1000) write -> err pulse, ack 0; then read 0x0 -> old contents unchanged.
REQ-027 BURST_EN: 4-beat read burst at 0x20, cti 010,010,010,111 -> ack on 4 consecutive cycles, data mem[8..11], FSM IDLE after; same stimulus without the macro -> 4 separate single-cycle acks with gaps.
REQ-028 Drop cyc, or pulse rst_n low, during WAIT (WAIT_STATES=3) -> no ack, no write, ack=0; the next read completes normally.

Source files
------------

// File: rtl/wshb_ram_slave.sv
// wshb_ram_slave: Wishbone B4 registered-feedback RAM responder; define WSHB_RAM_BURST_EN to add incremental bursts
module wshb_ram_slave #(
   parameter int ADDR_WIDTH  = 32,
   parameter int MEM_WORDS   = 1024,
   parameter int WAIT_STATES = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cyc,
   input  logic                  stb,
   input  logic [ADDR_WIDTH-1:0] adr,
   input  logic                  we,
   input  logic [31:0]           dat_ms,
   input  logic [3:0]            sel,
   input  logic [2:0]            cti,
   input  logic [1:0]            bte,
   output logic                  ack,
   output logic                  err,
   output logic                  rty,
   output logic [31:0]           dat_sm
);
   localparam int AW = $clog2(MEM_WORDS);
`ifdef WSHB_RAM_BURST_EN
   typedef enum logic [1:0] {IDLE, WAIT, ACK, BURST} state_t;
`else
   typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
`endif
   state_t        state_q;
   logic [2:0]    cnt_q;
   logic          ack_q, err_q;
   logic [31:0]   dat_q;
   logic [31:0]   mem [MEM_WORDS];
   logic [AW-1:0] idx, wr_idx;
   logic          oor, go_ack, wr_en;
   logic          unused_adr;
`ifdef WSHB_RAM_BURST_EN
   logic [AW-1:0] idx_q, idx_d;
   logic          beat;
`else
   logic          unused_burst;
   assign unused_burst = ^{cti, bte};
`endif
   assign unused_adr = ^adr[1:0];
   // Decode word index, range error, the edge that enters the ack cycle and the write strobe
   always_comb begin
      idx    = adr[2 +: AW];
      oor    = |(adr >> (AW + 2));
      go_ack = cyc && (state_q == IDLE ? stb && WAIT_STATES == 0 : state_q == WAIT && cnt_q == 3'd1);
      wr_en  = cyc && stb && we && ack_q;
`ifdef WSHB_RAM_BURST_EN
      beat   = ack_q && cyc && stb;
      idx_d  = state_q == ACK ? idx + AW'(1) : beat ? idx_q + AW'(1) : idx_q;
      wr_idx = state_q == ACK ? idx : idx_q;
`else
      wr_idx = idx;
`endif
   end
   // Transfer sequencing with registered ack/err/read data; responses default low each cycle
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         dat_q   <= '0;
`ifdef WSHB_RAM_BURST_EN
         idx_q   <= '0;
`endif
      end else begin
         ack_q <= go_ack && !oor;
         err_q <= go_ack && oor;
         dat_q <= go_ack && !oor ? mem[idx] : '0;
         case (state_q)
            IDLE: begin
               if (cyc && stb) state_q <= WAIT_STATES == 0 ? ACK : WAIT;
               cnt_q <= cyc && stb ? 3'(WAIT_STATES) : '0;
            end
            WAIT: begin
               state_q <= !cyc ? IDLE : cnt_q == 3'd1 ? ACK : WAIT;
               cnt_q   <= cyc ? cnt_q - 3'd1 : '0;
            end
`ifdef WSHB_RAM_BURST_EN
            ACK:
               if (ack_q && cyc && stb && cti == 3'b010 && bte == 2'b00) begin
                  state_q <= BURST;
                  idx_q   <= idx_d;
                  ack_q   <= 1'b1;
                  dat_q   <= mem[idx_d];
               end else state_q <= IDLE;
            BURST:
               if (!cyc || (beat && cti == 3'b111)) state_q <= IDLE;
               else begin
                  idx_q <= idx_d;
                  ack_q <= stb;
                  dat_q <= stb ? mem[idx_d] : '0;
               end
`else
            ACK: state_q <= IDLE;
`endif
            default: state_q <= IDLE;
         endcase
      end
   // Byte-masked write on the acknowledged beat; contents are deliberately not reset
   always_ff @(posedge clk)
      for (int i = 0; i < 4; i++)
         if (wr_en && sel[i]) mem[wr_idx][8*i +: 8] <= dat_ms[8*i +: 8];
   assign ack    = ack_q;
   assign err    = err_q;
   assign rty    = 1'b0;
   assign dat_sm = dat_q;
endmodule
